// File: rtl/aes_inv_round_if.sv
// Load/result bundle for aes_inv_round: the master drives the load strobe and the two
// 128-bit operands, and the slave returns the stage index and the registered state.
interface aes_inv_round_if;
  logic         valid;
  logic [127:0] matrix1;
  logic [127:0] matrix2;
  logic [1:0]   count;
  logic [127:0] matrix3;

  modport master (output valid, output matrix1, output matrix2,
                  input  count, input  matrix3);
  modport slave  (input  valid, input  matrix1, input  matrix2,
                  output count, output matrix3);
endinterface

// File: rtl/aes_inv_round.sv
// One AES inverse round without SubBytes (InvMixColumns, then InvShiftRows, then AddRoundKey),
// one stage per clock; count reports which stage matrix3 currently holds.
//   state | meaning
//   IDLE  | no operation; matrix3 holds the last result
//   S1    | matrix3 = InvMixColumns(matrix1)
//   S2    | matrix3 = InvShiftRows of S1 result
//   S3    | matrix3 = S2 result XOR key; may accept the next block
module aes_inv_round (
  input  logic          clk,
  input  logic          rst,
  aes_inv_round_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  state_t       state;
  logic [127:0] state_q;
  logic [127:0] key_reg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    for (int i = 0; i < 4; i++) begin
      res[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] v);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      res[127-32*c -: 32] = inv_mix_col(v[127-32*c -: 32]);
    end
    return res;
  endfunction

  // Row r moves right by r columns: the byte at column c lands in column (c+r) mod 4.
  function automatic logic [127:0] inv_shift(input logic [127:0] v);
    logic [127:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[127-8*(r+4*((c+r)%4)) -: 8] = v[127-8*(r+4*c) -: 8];
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      state_q <= '0;
      key_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            key_reg <= bus.matrix2;
            state_q <= inv_mix(bus.matrix1);
            state   <= S1;
          end
        end
        S1: begin
          state_q <= inv_shift(state_q);
          state   <= S2;
        end
        S2: begin
          state_q <= state_q ^ key_reg;
          state   <= S3;
        end
        S3: begin
          if (bus.valid) begin
            key_reg <= bus.matrix2;
            state_q <= inv_mix(bus.matrix1);
            state   <= S1;
          end else begin
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.count   = state;
  assign bus.matrix3 = state_q;

endmodule

// File: tb/tb_aes_inv_round.sv
// Directed and randomized bench for aes_inv_round. The reference model works on a 4x4 byte
// array with a generic GF(2^8) multiply and also models the forward round used for round trips.
module tb_aes_inv_round;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  aes_inv_round_if bus ();

  aes_inv_round dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish, got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic       hi;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] v, input bit inv);
    logic [7:0] s [4][4];
    logic [7:0] o [4][4];
    logic [7:0] k [4];
    logic [127:0] res;
    if (inv) begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = v[127-8*(r+4*c) -: 8];
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        o[i][c] = 8'h00;
        for (int j = 0; j < 4; j++) o[i][c] = o[i][c] ^ gmul(k[j], s[(i+j)%4][c]);
      end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(r+4*c) -: 8] = o[r][c];
    return res;
  endfunction

  // inv=0: row r rotates left by r; inv=1: row r rotates right by r.
  function automatic logic [127:0] ref_shift(input logic [127:0] v, input bit inv);
    logic [7:0] s [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = v[127-8*(r+4*c) -: 8];
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(r+4*c) -: 8] = inv ? s[r][(c+4-r)%4] : s[r][(c+r)%4];
    return res;
  endfunction

  function automatic logic [127:0] fwd_round(input logic [127:0] pt, input logic [127:0] key);
    return ref_mix(ref_shift(pt ^ key, 1'b0), 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h required=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.valid   = 1'b0;
    bus.matrix1 = {$urandom, $urandom, $urandom, $urandom};
    bus.matrix2 = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Loads one block and checks every stage against the model, leaving the DUT in S3.
  task automatic run_block(input string tag, input logic [127:0] m1, input logic [127:0] key);
    logic [127:0] e1, e2, e3;
    e1 = ref_mix(m1, 1'b1);
    e2 = ref_shift(e1, 1'b1);
    e3 = e2 ^ key;
    bus.valid = 1'b1; bus.matrix1 = m1; bus.matrix2 = key;
    tick();
    drive_idle();
    chk({tag, ".c1"}, 128'(bus.count), 128'(1)); chk({tag, ".m1"}, bus.matrix3, e1);
    tick();
    chk({tag, ".c2"}, 128'(bus.count), 128'(2)); chk({tag, ".m2"}, bus.matrix3, e2);
    tick();
    chk({tag, ".c3"}, 128'(bus.count), 128'(3)); chk({tag, ".m3"}, bus.matrix3, e3);
  endtask

  localparam logic [127:0] KEY = 128'h54686973_49734153_65637265_744B6579;

  initial begin
    logic [127:0] pt, ct, hold, d_a, d_b;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive_idle();
    tick(); tick(); tick();
    chk("rst.count", 128'(bus.count), 128'(0));
    chk("rst.m3", bus.matrix3, 128'(0));
    rst = 1'b0;

    // Constant columns, key 0: InvMix fixed point, then row rotation visible.
    run_block("const", 128'h01010101_02020202_03030303_04040404, 128'(0));
    chk("const.lit1", ref_mix(128'h01010101_02020202_03030303_04040404, 1'b1),
        128'h01010101_02020202_03030303_04040404);
    chk("const.lit3", bus.matrix3, 128'h01040302_02010403_03020104_04030201);
    tick();
    chk("idle.count", 128'(bus.count), 128'(0));
    chk("idle.hold", bus.matrix3, 128'h01040302_02010403_03020104_04030201);
    tick();
    chk("idle.hold2", bus.matrix3, 128'h01040302_02010403_03020104_04030201);

    run_block("vec_a", {4{32'h8e4da1bc}}, 128'(0));
    chk("vec_a.lit", bus.matrix3, {4{32'hdb135345}});
    tick();
    run_block("vec_b", {4{32'h9fdc589d}}, 128'(0));
    chk("vec_b.lit", bus.matrix3, {4{32'hf20a225c}});
    tick();
    run_block("keyadd", 128'(0), KEY);
    chk("keyadd.lit", bus.matrix3, KEY);
    tick();

    // Valid during S1/S2 must be ignored; valid in S3 starts the next block at once.
    pt = {$urandom, $urandom, $urandom, $urandom};
    hold = ref_shift(ref_mix(pt, 1'b1), 1'b1) ^ KEY;
    bus.valid = 1'b1; bus.matrix1 = pt; bus.matrix2 = KEY;
    tick();
    bus.valid = 1'b1; bus.matrix1 = ~pt; bus.matrix2 = ~KEY;
    tick();
    bus.valid = 1'b1; bus.matrix1 = pt ^ 128'h5a; bus.matrix2 = 128'(0);
    tick();
    chk("hs.c3", 128'(bus.count), 128'(3));
    chk("hs.m3", bus.matrix3, hold);
    d_a = {$urandom, $urandom, $urandom, $urandom};
    d_b = {$urandom, $urandom, $urandom, $urandom};
    run_block("b2b", d_a, d_b);
    tick();

    // Async reset mid-S2 clears before the next edge; a later load restarts cleanly.
    bus.valid = 1'b1; bus.matrix1 = d_b; bus.matrix2 = d_a;
    tick();
    drive_idle();
    tick();
    chk("mid.pre", 128'(bus.count), 128'(2));
    #2 rst = 1'b1;
    #1;
    chk("mid.count", 128'(bus.count), 128'(0));
    chk("mid.m3", bus.matrix3, 128'(0));
    tick();
    rst = 1'b0;
    run_block("restart", d_a, KEY);
    tick();

    // Round trip with back-to-back accepts in S3.
    for (int i = 0; i < 3072; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = fwd_round(pt, KEY);
      bus.valid = 1'b1; bus.matrix1 = ct; bus.matrix2 = KEY;
      tick();
      drive_idle();
      tick();
      tick();
      chk("rt.count", 128'(bus.count), 128'(3));
      chk("rt.pt", bus.matrix3, pt);
    end
    drive_idle();
    tick();
    chk("end.idle", 128'(bus.count), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
